// File: rtl/fft_config_sched.sv
// Round-robin FFT config sequencer: waits for the core to drain, then sends one config beat.
// Optional FFT_CFG_SKIP_REDUNDANT_EN acks repeats of the last sent word without resending it.
module fft_config_sched #(
   parameter int NUM_REQ = 2,
   parameter int SCALE_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*SCALE_W-1:0] req_scale,
   input  logic [NUM_REQ-1:0]         req_forward,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [1:0]                 grant_id,
   output logic                       cfg_tvalid,
   input  logic                       cfg_tready,
   output logic                       cfg_tlast,
   output logic [15:0]                cfg_tdata,
   input  logic                       frame_in_last,
   input  logic                       frame_out_last,
   output logic                       cfg_hold
);

   typedef enum logic [1:0] {IDLE, DRAIN, SEND, ACK} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [3:0]           cnt;
   logic [SCALE_W-1:0]   scale_q;
   logic                 fwd_q;
   logic [15:0]          word;
   logic                 gnt_found;
   logic [1:0]           gid_nxt;
   logic [2:0]           sum;
   logic [SCALE_W-1:0]   sel_scale;
   logic                 sel_fwd;
   logic                 redundant;

   assign word      = 16'({scale_q, fwd_q});
   assign cfg_tlast = cfg_tvalid;

`ifdef FFT_CFG_SKIP_REDUNDANT_EN
   logic [SCALE_W:0]     last_word;
   logic                 last_vld;

   assign redundant = last_vld && (last_word == {scale_q, fwd_q});

   always_ff @(posedge clk) begin
      if (reset) begin
         last_word <= '0;
         last_vld  <= 1'b0;
      end else if (state == SEND && cfg_tvalid && cfg_tready) begin
         last_word <= {scale_q, fwd_q};
         last_vld  <= 1'b1;
      end
   end
`else
   assign redundant = 1'b0;
`endif

   // Frames in flight; simultaneous in/out cancel out
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 4'd0;
      end else if (frame_in_last && !frame_out_last) begin
         if (cnt != 4'hF) cnt <= cnt + 4'd1;
      end else if (!frame_in_last && frame_out_last) begin
         if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
   end

   // Round-robin search starting one past the last grant
   always_comb begin
      gnt_found = 1'b0;
      gid_nxt   = grant_id;
      sum       = 3'd0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         sum = {1'b0, grant_id} + 3'(off);
         if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && sum == 3'(i) && req_valid[i]) begin
               gnt_found = 1'b1;
               gid_nxt   = 2'(i);
            end
         end
      end
   end

   always_comb begin
      sel_scale = '0;
      sel_fwd   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gid_nxt == 2'(i)) begin
            sel_scale = req_scale[i*SCALE_W +: SCALE_W];
            sel_fwd   = req_forward[i];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_found) state_nxt = DRAIN;
         DRAIN: begin
            if (redundant)           state_nxt = ACK;
            else if (cnt == 4'd0)    state_nxt = SEND;
         end
         SEND:    if (cfg_tvalid && cfg_tready) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so no input reaches them directly
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant_id   <= 2'(NUM_REQ-1);
         scale_q    <= '0;
         fwd_q      <= 1'b0;
         cfg_tvalid <= 1'b0;
         cfg_tdata  <= 16'd0;
         cfg_hold   <= 1'b0;
         req_ack    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && gnt_found) begin
            grant_id <= gid_nxt;
            scale_q  <= sel_scale;
            fwd_q    <= sel_fwd;
         end
         cfg_tvalid <= (state_nxt == SEND);
         cfg_tdata  <= (state_nxt == SEND) ? word : 16'd0;
         cfg_hold   <= (state_nxt != IDLE);
         for (int i = 0; i < NUM_REQ; i++) begin
            req_ack[i] <= (state_nxt == ACK) && (grant_id == 2'(i));
         end
      end
   end

endmodule

// File: doc/fft_config_sched.md
# fft_config_sched

Arbitrates FFT configuration requests from up to four requesters and sequences them onto the FFT core's single-beat AXI-Stream config channel. It sits between the per-channel register banks and the FFT config port. It applies a new configuration only when no frames are in flight inside the core. While a reconfiguration is pending it raises `cfg_hold`, so that the upstream data mux stops starting new frames.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `SCALE_W`, 8: scale-schedule width, legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester level request; held until matching `req_ack`.
- `req_scale`  in  NUM_REQ*SCALE_W  scale schedules; requester i in bits [i*SCALE_W +: SCALE_W].
- `req_forward`  in  NUM_REQ  1 = forward FFT, 0 = inverse.
- `req_ack`  out  NUM_REQ  one-cycle pulse: requester's config accepted by core.
- `grant_id`  out  2  index of current or last granted requester.
- `cfg_tvalid`  out  1  config channel valid.
- `cfg_tready`  in  1  config channel ready.
- `cfg_tlast`  out  1  equals `cfg_tvalid` (single-beat transfers).
- `cfg_tdata`  out  16  {zeros, scale, forward}.
- `frame_in_last`  in  1  pulse: last beat of an input frame accepted by core.
- `frame_out_last`  in  1  pulse: last beat of an output frame left the core.
- `cfg_hold`  out  1  high while a reconfiguration is pending.

## Operation
- Behaviour is decided: one clock; reset is synchronous and active-high.
- Outstanding-frame counter, 4 bits:
  - +1 on `frame_in_last`, −1 on `frame_out_last`.
  - Both pulses in the same cycle leave the count unchanged.
  - Saturates at 15; a decrement at 0 is ignored.
- FSM states: IDLE, DRAIN, SEND, ACK.
  - IDLE: if any `req_valid` is high, grant round-robin. The search starts at (last grant + 1) mod NUM_REQ. Latch the winner's scale, forward and id. Go to DRAIN.
  - DRAIN: when the counter equals 0, go to SEND. Otherwise stay in DRAIN.
  - SEND: `cfg_tvalid` = `cfg_tlast` = 1, with `cfg_tdata` driven from the latched values. On `cfg_tvalid & cfg_tready`, go to ACK.
  - ACK: drive `req_ack[grant_id]` = 1 for exactly one cycle, then go to IDLE.
- Requests are never sampled in DRAIN, SEND or ACK. Changes to `req_*` after the grant have no effect on the config word.
- `cfg_tdata`: bit 0 = forward, bits [SCALE_W:1] = scale, upper bits = 0. In SEND the word stays stable until the handshake completes.
- `cfg_hold` = 1 in the DRAIN, SEND and ACK states.
- Reset values:
  - Outputs: `cfg_tvalid`, `cfg_tlast`, `cfg_tdata`, `req_ack`, `cfg_hold` all 0. `grant_id` = NUM_REQ−1, so requester 0 wins first.
  - Internal: counter = 0, FSM in IDLE.
- Reset mid-transfer drops `cfg_tvalid` on the next edge. No `req_ack` is issued for that request; the requester re-arbitrates after reset.

## Timing
- Request seen in IDLE at cycle 0, counter = 0:
  - DRAIN at cycle 1.
  - `cfg_tvalid` high at cycle 2.
  - Handshake in cycle k gives `req_ack` in cycle k+1.
  - IDLE at k+2; the earliest next grant is at k+2.
- All outputs are registered. There is no combinational path from any input to any output.
- `cfg_tready` may be high before `cfg_tvalid`. The handshake is counted only in a cycle where both are high.
- A requester must deassert `req_valid` on the edge following its `req_ack`. Otherwise it is re-arbitrated.

## Configuration
- Macro: `FFT_CFG_SKIP_REDUNDANT_EN`.
- Defined:
  - The block stores the last transmitted {scale, forward} plus a valid bit, which is cleared by reset.
  - If the latched request equals the stored word and the valid bit is set, DRAIN goes directly to ACK. There is no counter wait and no `cfg_tvalid`.
  - `req_ack` still pulses, at cycle 2 after the grant.
- Undefined: every grant is transmitted, even if identical to the previous word.

## Test plan
- Single request: req0 with scale 0xAA, forward 1, `cfg_tready` = 1, counter 0 -> `cfg_tvalid` at cycle 2 with `cfg_tdata` = 0x0155; `req_ack[0]` at cycle 3; `cfg_hold` high for cycles 1–3.
- Backpressure: `cfg_tready` held low for 5 cycles in SEND -> `cfg_tvalid`/`cfg_tdata` stable throughout; exactly one `req_ack` after `cfg_tready` rises.
- Round-robin: req0 and req1 asserted together after reset -> req0 acked, then req1. Then re-assert both -> req0, then req1 again, alternating. Requester 1 is never starved.
- Drain:
  - Two `frame_in_last` pulses, then a request -> `cfg_tvalid` stays low until two `frame_out_last` pulses arrive.
  - Simultaneous in/out pulse -> count unchanged.
- Reset during SEND with `cfg_tready` = 0 -> `cfg_tvalid` = 0 and `cfg_hold` = 0 on the next edge; no `req_ack`; `grant_id` = NUM_REQ−1.
- With `FFT_CFG_SKIP_REDUNDANT_EN`: same config requested twice -> one transfer only; the second `req_ack` at cycle 2 after the grant. A changed forward bit -> transmitted normally.
